// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU opcodes, arbiter FSM states and opcode legality helper
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_XOR  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_AND  = 4'd4;
  localparam logic [3:0] ALU_SLL  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_SLT  = 4'd8;
  localparam logic [3:0] ALU_SLTU = 4'd9;
  localparam logic [3:0] ALU_EQL  = 4'd10;
  localparam logic [3:0] ALU_NEQ  = 4'd11;
  localparam logic [3:0] ALU_GTE  = 4'd12;
  localparam logic [3:0] ALU_GTEU = 4'd13;
  localparam logic [3:0] ALU_ERR  = 4'd15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Opcodes 14 and 15 have no ALU meaning
  function automatic logic is_illegal_op(input logic [3:0] op);
    return (op == 4'd14) || (op == ALU_ERR);
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin pick starting at the rotating pointer
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic [NUM_REQ-1:0] i_req,
  input  logic [ID_W-1:0]    i_rr_ptr,
  output logic [NUM_REQ-1:0] o_grant,
  output logic [ID_W-1:0]    o_grant_idx,
  output logic               o_any_grant
);

  always_comb begin
    o_grant     = '0;
    o_grant_idx = '0;
    o_any_grant = 1'b0;
    for (int k = 0; k < NUM_REQ; k++) begin
      int j;
      j = int'(i_rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!o_any_grant && i_req[j]) begin
        o_any_grant = 1'b1;
        o_grant_idx = ID_W'(j);
        o_grant[j]  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// rtl/alu_share_arbiter.sv - round-robin sharing of one registered ALU between NUM_REQ requesters
// Optional illegal-opcode flagging under macro ALU_OP_CHECK_EN.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int NUM_REQ = 2,
  parameter int ID_W    = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_REQ-1:0]      req_valid,
  output logic [NUM_REQ-1:0]      req_ready,
  input  logic [4*NUM_REQ-1:0]    req_op,
  input  logic [32*NUM_REQ-1:0]   req_a,
  input  logic [32*NUM_REQ-1:0]   req_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [ID_W-1:0]         rsp_id,
  output logic [31:0]             rsp_data,
  output logic                    rsp_err,
  output logic [31:0]             alu_in_1,
  output logic [31:0]             alu_in_2,
  output logic [3:0]              alu_op,
  input  logic [31:0]             alu_out
);

  state_t            r_state;
  logic [ID_W-1:0]   r_rr_ptr;
  logic [ID_W-1:0]   r_id;
  logic [3:0]        r_op;
  logic [31:0]       r_a;
  logic [31:0]       r_b;
  logic [31:0]       r_rsp_data;
  logic              r_rsp_valid;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_grant_idx;
  logic               w_any_grant;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .i_req       (req_valid),
    .i_rr_ptr    (r_rr_ptr),
    .o_grant     (w_grant),
    .o_grant_idx (w_grant_idx),
    .o_any_grant (w_any_grant)
  );

  // Grant is only visible while idle and out of reset
  assign req_ready = w_grant & {NUM_REQ{(r_state == ST_IDLE) && reset_n}};

`ifdef ALU_OP_CHECK_EN
  logic r_rsp_err;
  assign rsp_err = r_rsp_err;
`else
  assign rsp_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_id        <= '0;
      r_op        <= '0;
      r_a         <= '0;
      r_b         <= '0;
      r_rsp_data  <= '0;
      r_rsp_valid <= 1'b0;
`ifdef ALU_OP_CHECK_EN
      r_rsp_err   <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any_grant) begin
            r_op     <= req_op[{w_grant_idx, 2'b00} +: 4];
            r_a      <= req_a[{w_grant_idx, 5'b00000} +: 32];
            r_b      <= req_b[{w_grant_idx, 5'b00000} +: 32];
            r_id     <= w_grant_idx;
            r_rr_ptr <= (w_grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : w_grant_idx + ID_W'(1);
            r_state  <= ST_EXEC;
          end
        end
        ST_EXEC: begin
`ifdef ALU_OP_CHECK_EN
          if (is_illegal_op(r_op)) begin
            r_rsp_data <= '0;
            r_rsp_err  <= 1'b1;
          end else begin
            r_rsp_data <= alu_out;
            r_rsp_err  <= 1'b0;
          end
`else
          r_rsp_data <= alu_out;
`endif
          r_rsp_valid <= 1'b1;
          r_state     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_rsp_valid <= 1'b0;
          r_state     <= ST_IDLE;
        end
      endcase
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_rsp_data;
  assign alu_op    = r_op;
  assign alu_in_1  = r_a;
  assign alu_in_2  = r_b;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// tb/tb_alu_share_arbiter.sv - directed self-checking bench with a behavioural ALU
module tb_alu_share_arbiter;

  localparam int NUM_REQ = 3;
  localparam int ID_W    = 2;

  logic                  clk = 1'b0;
  logic                  reset_n;
  logic [NUM_REQ-1:0]    req_valid;
  logic [NUM_REQ-1:0]    req_ready;
  logic [4*NUM_REQ-1:0]  req_op;
  logic [32*NUM_REQ-1:0] req_a;
  logic [32*NUM_REQ-1:0] req_b;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [ID_W-1:0]       rsp_id;
  logic [31:0]           rsp_data;
  logic                  rsp_err;
  logic [31:0]           alu_in_1;
  logic [31:0]           alu_in_2;
  logic [3:0]            alu_op;
  logic [31:0]           alu_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_share_arbiter #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_op    (req_op),
    .req_a     (req_a),
    .req_b     (req_b),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .alu_in_1  (alu_in_1),
    .alu_in_2  (alu_in_2),
    .alu_op    (alu_op),
    .alu_out   (alu_out)
  );

  always_comb begin
    case (alu_op)
      4'd0:    alu_out = alu_in_1 + alu_in_2;
      4'd1:    alu_out = alu_in_1 - alu_in_2;
      4'd2:    alu_out = alu_in_1 ^ alu_in_2;
      4'd3:    alu_out = alu_in_1 | alu_in_2;
      4'd4:    alu_out = alu_in_1 & alu_in_2;
      4'd8:    alu_out = {31'd0, $signed(alu_in_1) < $signed(alu_in_2)};
      4'd9:    alu_out = {31'd0, alu_in_1 < alu_in_2};
      default: alu_out = 32'd329010;
    endcase
  end

  task automatic set_req(input int i, input logic v, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b);
    req_valid[i]      = v;
    req_op[4*i +: 4]  = op;
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
  endtask

  task automatic test_reset();
    reset_n   = 1'b0;
    rsp_ready = 1'b1;
    req_valid = '0;
    req_op    = '0;
    req_a     = '0;
    req_b     = '0;
    repeat (2) @(negedge clk);
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    checks++; if (req_ready !== 3'b000) begin errors++; $display("FAIL reset_req_ready got %b want 000", req_ready); end
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid got %b want 0", rsp_valid); end
    checks++; if (rsp_data !== 32'd0 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL reset_rsp_regs got data=%h id=%0d err=%b want 0/0/0", rsp_data, rsp_id, rsp_err); end
    checks++; if (alu_in_1 !== 32'd0 || alu_in_2 !== 32'd0 || alu_op !== 4'd0) begin errors++;
      $display("FAIL reset_alu_regs got %h %h %h want 0", alu_in_1, alu_in_2, alu_op); end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_first_grant got %b want 001", req_ready); end
    @(negedge clk);
    #1;
    checks++; if (alu_in_1 !== 32'd5 || alu_in_2 !== 32'd7) begin errors++;
      $display("FAIL reset_exec_operands got %0d %0d want 5 7", alu_in_1, alu_in_2); end
    reset_n = 1'b0;
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 3'b000) begin errors++;
      $display("FAIL reset_mid_exec got valid=%b ready=%b want 0 000", rsp_valid, req_ready); end
    checks++; if (alu_in_1 !== 32'd0) begin errors++; $display("FAIL reset_mid_exec_op1 got %0d want 0", alu_in_1); end
    @(negedge clk);
    reset_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_stale_rsp cycle %0d got %b want 0", c, rsp_valid); end
    end
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    set_req(1, 1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL reset_rr_ptr got %b want 001", req_ready); end
    req_valid = '0;
  endtask

  task automatic test_fairness();
    logic [2:0]  exp_ready [4];
    logic [1:0]  exp_id    [4];
    logic [31:0] exp_data  [4];
    exp_ready = '{3'b001, 3'b010, 3'b001, 3'b010};
    exp_id    = '{2'd0, 2'd1, 2'd0, 2'd1};
    exp_data  = '{32'd7, 32'd1, 32'd7, 32'd1};
    rsp_ready = 1'b1;
    @(negedge clk);
    set_req(0, 1'b1, 4'd1, 32'd10, 32'd3);
    set_req(1, 1'b1, 4'd8, 32'hFFFF_FFFF, 32'd0);
    for (int t = 0; t < 4; t++) begin
      #1;
      checks++; if (req_ready !== exp_ready[t]) begin errors++; $display("FAIL fair_grant %0d got %b want %b", t, req_ready, exp_ready[t]); end
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b0 || req_ready !== 3'b000) begin errors++;
        $display("FAIL fair_exec %0d got valid=%b ready=%b want 0 000", t, rsp_valid, req_ready); end
      @(negedge clk);
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_id !== exp_id[t] || rsp_data !== exp_data[t]) begin errors++;
        $display("FAIL fair_rsp %0d got v=%b id=%0d data=%0d want 1 %0d %0d", t, rsp_valid, rsp_id, rsp_data, exp_id[t], exp_data[t]); end
      if (t == 3) req_valid = '0;
      @(negedge clk);
    end
  endtask

  task automatic test_single_op();
    rsp_ready = 1'b1;
    set_req(0, 1'b1, 4'd0, 32'd5, 32'd7);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL single_grant got %b want 001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (rsp_valid !== 1'b0 || alu_op !== 4'd0 || alu_in_1 !== 32'd5 || alu_in_2 !== 32'd7) begin errors++;
      $display("FAIL single_exec got v=%b op=%0d a=%0d b=%0d want 0 0 5 7", rsp_valid, alu_op, alu_in_1, alu_in_2); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'd12 || rsp_id !== 2'd0 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL single_rsp got v=%b data=%0d id=%0d err=%b want 1 12 0 0", rsp_valid, rsp_data, rsp_id, rsp_err); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_rsp_drop got %b want 0", rsp_valid); end
  endtask

  task automatic test_backpressure();
    rsp_ready = 1'b0;
    @(negedge clk);
    set_req(0, 1'b1, 4'd2, 32'h0000_00F0, 32'h0000_00FF);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL bp_grant got %b want 001", req_ready); end
    @(negedge clk);
    set_req(0, 1'b0, 4'd0, 32'd0, 32'd0);
    set_req(1, 1'b1, 4'd0, 32'd1, 32'd1);
    @(negedge clk);
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (rsp_valid !== 1'b1 || rsp_data !== 32'h0000_000F || rsp_id !== 2'd0 || req_ready !== 3'b000) begin errors++;
        $display("FAIL bp_hold %0d got v=%b data=%h id=%0d ready=%b want 1 0000000f 0 000", c, rsp_valid, rsp_data, rsp_id, req_ready); end
      if (c == 4) rsp_ready = 1'b1;
      @(negedge clk);
    end
    #1;
    checks++; if (rsp_valid !== 1'b0 || req_ready !== 3'b010) begin errors++;
      $display("FAIL bp_release got v=%b ready=%b want 0 010", rsp_valid, req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_wrap();
    rsp_ready = 1'b1;
    set_req(1, 1'b1, 4'd3, 32'h0000_0F00, 32'h0000_000F);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL wrap_prep_grant got %b want 010", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (rsp_data !== 32'h0000_0F0F || rsp_id !== 2'd1) begin errors++;
      $display("FAIL wrap_prep_rsp got %h id %0d want 00000f0f 1", rsp_data, rsp_id); end
    @(negedge clk);
    set_req(0, 1'b1, 4'd4, 32'h0000_00FF, 32'h0000_003C);
    #1;
    checks++; if (req_ready !== 3'b001) begin errors++; $display("FAIL wrap_grant got %b want 001", req_ready); end
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (rsp_data !== 32'h0000_003C || rsp_id !== 2'd0) begin errors++;
      $display("FAIL wrap_rsp got %h id %0d want 0000003c 0", rsp_data, rsp_id); end
    @(negedge clk);
    set_req(0, 1'b1, 4'd0, 32'd1, 32'd1);
    set_req(1, 1'b1, 4'd0, 32'd2, 32'd2);
    set_req(2, 1'b1, 4'd0, 32'd3, 32'd3);
    #1;
    checks++; if (req_ready !== 3'b010) begin errors++; $display("FAIL wrap_ptr_next got %b want 010", req_ready); end
    req_valid = '0;
    @(negedge clk);
  endtask

  task automatic test_op_check();
    logic [31:0] exp_data;
    logic        exp_err;
`ifdef ALU_OP_CHECK_EN
    exp_data = 32'd0;
    exp_err  = 1'b1;
`else
    exp_data = 32'd329010;
    exp_err  = 1'b0;
`endif
    rsp_ready = 1'b1;
    set_req(2, 1'b1, 4'd15, 32'd1, 32'd2);
    #1;
    checks++; if (req_ready !== 3'b100) begin errors++; $display("FAIL opchk_grant got %b want 100", req_ready); end
    @(negedge clk);
    req_valid = '0;
    #1;
    checks++; if (alu_op !== 4'd15) begin errors++; $display("FAIL opchk_alu_op got %0d want 15", alu_op); end
    @(negedge clk);
    #1;
    checks++; if (rsp_valid !== 1'b1 || rsp_data !== exp_data || rsp_err !== exp_err || rsp_id !== 2'd2) begin errors++;
      $display("FAIL opchk_rsp got v=%b data=%0d err=%b id=%0d want 1 %0d %b 2", rsp_valid, rsp_data, rsp_err, rsp_id, exp_data, exp_err); end
    @(negedge clk);
    set_req(2, 1'b1, 4'd0, 32'd40, 32'd2);
    @(negedge clk);
    req_valid = '0;
    @(negedge clk);
    #1;
    checks++; if (rsp_data !== 32'd42 || rsp_err !== 1'b0) begin errors++;
      $display("FAIL opchk_legal got data=%0d err=%b want 42 0", rsp_data, rsp_err); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_fairness();
    test_single_op();
    test_backpressure();
    test_wrap();
    test_op_check();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
